// File: rtl/hqc_decap_stream_io_if.sv
// Stream and core-port bundle for the HQC decap host wrapper. The master modport is the wrapper's
// view; the slave modport is the host/core side.
interface hqc_decap_stream_io_if #(
  parameter int RAMWIDTH     = 128,
  parameter int LOG_RAMDEPTH = 8
);
  logic [31:0]             s_tdata;
  logic                    s_tvalid;
  logic                    s_tready;
  logic [31:0]             m_tdata;
  logic                    m_tvalid;
  logic                    m_tready;
  logic                    m_tlast;
  logic                    decap_start;
  logic                    decap_done;
  logic [1:0]              decap_in_type;
  logic [RAMWIDTH-1:0]     decap_in;
  logic [LOG_RAMDEPTH-1:0] decap_in_addr;
  logic                    decap_in_wen;
  logic                    decap_out_en;
  logic [LOG_RAMDEPTH-1:0] decap_out_addr;
  logic [31:0]             decap_out;

  modport master (
    input  s_tdata, s_tvalid, m_tready, decap_done, decap_out,
    output s_tready, m_tdata, m_tvalid, m_tlast, decap_start, decap_in_type,
           decap_in, decap_in_addr, decap_in_wen, decap_out_en, decap_out_addr
  );

  modport slave (
    output s_tdata, s_tvalid, m_tready, decap_done, decap_out,
    input  s_tready, m_tdata, m_tvalid, m_tlast, decap_start, decap_in_type,
           decap_in, decap_in_addr, decap_in_wen, decap_out_en, decap_out_addr
  );
endinterface

// File: rtl/hqc_decap_stream_io.sv
// Loads u/v/d from a 32-bit stream into the HQC decap core, starts it, times it, and streams the
// shared secret out. Load writes land 1 cycle after the last sub-word; readout is 2 cycles/word and holds on m_tready=0.
module hqc_decap_stream_io #(
  parameter        parameter_set = "hqc128",
  parameter int    RAMWIDTH      = 128,
  parameter int    RAMDEPTH      = (((parameter_set == "hqc256") ? 57637 :
                                     (parameter_set == "hqc192") ? 35851 : 17669)
                                    + RAMWIDTH - 1) / RAMWIDTH,
  parameter int    LOG_RAMDEPTH  = $clog2(RAMDEPTH),
  parameter int    V_LINES       = RAMDEPTH - 1,
  parameter int    D_WORDS       = 16,
  parameter int    SS_WORDS      = 16,
  parameter bit    BYTE_SWAP     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  hqc_decap_stream_io_if.master io,
  output logic                  busy,
  output logic [31:0]           cycle_count
);

  localparam int SUBW = RAMWIDTH / 32;
  localparam int SW   = $clog2(SUBW);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD_U   = 3'd1;
  localparam logic [2:0] LOAD_V   = 3'd2;
  localparam logic [2:0] LOAD_D   = 3'd3;
  localparam logic [2:0] START    = 3'd4;
  localparam logic [2:0] WAIT     = 3'd5;
  localparam logic [2:0] RD_ISSUE = 3'd6;
  localparam logic [2:0] RD_HOLD  = 3'd7;

  logic [2:0]              state;
  logic [SW-1:0]           sub;
  logic [15:0]             line_cnt;
  logic [RAMWIDTH-1:0]     line_buf;
  logic [RAMWIDTH-1:0]     line_nxt;
  logic [7:0]              k;
  logic [31:0]             lat_cnt;
  logic                    fresh;
  logic [31:0]             hold_dat;
  logic [31:0]             swap_dat;
  logic [RAMWIDTH-1:0]     in_dat;
  logic [LOG_RAMDEPTH-1:0] in_addr;
  logic [1:0]              in_type;
  logic                    in_wen;
  logic                    s_rdy;
  logic                    accept;
  logic                    last_sub;
  logic                    last_line;
  int                      line_lim;

  always_comb begin
    s_rdy = (state == LOAD_U) || (state == LOAD_V) ||
            ((state == LOAD_D) && (line_cnt != 16'(D_WORDS)));
    accept    = s_rdy && io.s_tvalid;
    last_sub  = (sub == SW'(SUBW - 1));
    line_lim  = (state == LOAD_U) ? RAMDEPTH : V_LINES;
    last_line = (line_cnt == 16'(line_lim - 1));
    line_nxt  = line_buf;
    line_nxt[32*sub +: 32] = io.s_tdata;
  end

  assign swap_dat = BYTE_SWAP ? {io.decap_out[7:0], io.decap_out[15:8],
                                 io.decap_out[23:16], io.decap_out[31:24]}
                              : io.decap_out;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      sub         <= '0;
      line_cnt    <= '0;
      line_buf    <= '0;
      k           <= '0;
      lat_cnt     <= '0;
      cycle_count <= '0;
      fresh       <= 1'b0;
      hold_dat    <= '0;
      in_dat      <= '0;
      in_addr     <= '0;
      in_type     <= 2'd2;
      in_wen      <= 1'b0;
    end else begin
      in_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (io.s_tvalid) begin
            state    <= LOAD_U;
            line_cnt <= '0;
            sub      <= '0;
          end
        end
        LOAD_U, LOAD_V: begin
          if (accept) begin
            line_buf <= line_nxt;
            sub      <= last_sub ? '0 : sub + SW'(1);
            if (last_sub) begin
              in_wen  <= 1'b1;
              in_dat  <= line_nxt;
              in_addr <= LOG_RAMDEPTH'(line_cnt);
              in_type <= (state == LOAD_U) ? 2'd2 : 2'd3;
              if (last_line) begin
                line_cnt <= '0;
                state    <= (state == LOAD_U) ? LOAD_V : LOAD_D;
              end else begin
                line_cnt <= line_cnt + 16'd1;
              end
            end
          end
        end
        LOAD_D: begin
          if (accept) begin
            in_wen   <= 1'b1;
            in_dat   <= {{(RAMWIDTH-32){1'b0}}, io.s_tdata};
            in_addr  <= LOG_RAMDEPTH'(line_cnt);
            in_type  <= 2'd1;
            line_cnt <= line_cnt + 16'd1;
          end else if (line_cnt == 16'(D_WORDS)) begin
            // last d write is on the bus this cycle; start the core after it
            state <= START;
          end
        end
        START: begin
          lat_cnt <= 32'd1;
          state   <= WAIT;
        end
        WAIT: begin
          if (io.decap_done) begin
            cycle_count <= lat_cnt;
            k           <= '0;
            state       <= RD_ISSUE;
          end else if (lat_cnt != '1) begin
            lat_cnt <= lat_cnt + 32'd1;
          end
        end
        RD_ISSUE: begin
          fresh <= 1'b1;
          state <= RD_HOLD;
        end
        RD_HOLD: begin
          fresh <= 1'b0;
          if (fresh) hold_dat <= swap_dat;
          if (io.m_tready) begin
            if (k == 8'(SS_WORDS - 1)) begin
              state <= IDLE;
            end else begin
              k     <= k + 8'd1;
              state <= RD_ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // read data is passed straight through on its arrival cycle, then held from the register
  assign io.m_tdata       = fresh ? swap_dat : hold_dat;
  assign io.m_tvalid      = (state == RD_HOLD);
  assign io.m_tlast       = (state == RD_HOLD) && (k == 8'(SS_WORDS - 1));
  assign io.s_tready      = s_rdy;
  assign io.decap_start   = (state == START);
  assign io.decap_out_en  = (state == RD_ISSUE);
  assign io.decap_out_addr = (state == RD_ISSUE) ? LOG_RAMDEPTH'(k) : '0;
  assign io.decap_in      = in_dat;
  assign io.decap_in_addr = in_addr;
  assign io.decap_in_type = in_type;
  assign io.decap_in_wen  = in_wen;
  assign busy             = (state != IDLE);

endmodule
